// File: rtl/secp256k1_addsub_mod.sv
// Two-stage pipelined modular add/subtract over the secp256k1 prime field.
// Stage 1 forms the raw sum/difference; stage 2 applies one modular correction.
module secp256k1_addsub_mod #(
    parameter int                  DAT_BITS = 256,
    parameter int                  CTL_BITS = 16,
    parameter logic [DAT_BITS-1:0] P        = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [DAT_BITS-1:0] i_dat_a,
    input  logic [DAT_BITS-1:0] i_dat_b,
    input  logic                i_sub,
    input  logic [CTL_BITS-1:0] i_ctl,
    input  logic                i_err,
    input  logic                i_val,
    output logic                o_rdy,
    output logic [DAT_BITS-1:0] o_dat,
    output logic [CTL_BITS-1:0] o_ctl,
    output logic                o_err,
    output logic                o_val,
    input  logic                i_rdy
);

    function automatic logic out_of_range(input logic [DAT_BITS-1:0] v);
        return (v >= P);
    endfunction

    logic                s1_val_r;
    logic [DAT_BITS:0]   s1_sum_r;
    logic                s1_sub_r;
    logic [CTL_BITS-1:0] s1_ctl_r;
    logic                s1_err_r;

    logic                s2_adv_s;
    logic                s1_adv_s;
    logic [DAT_BITS:0]   s1_sum_s;
    logic                s1_err_s;
    logic [DAT_BITS-1:0] s2_res_s;

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_adv_s = ~o_val | i_rdy;
    assign s1_adv_s = ~s1_val_r | s2_adv_s;
    assign o_rdy    = s1_adv_s;

    // Stage 1 arithmetic: the extra top bit carries the add carry or the sub borrow.
    always_comb begin
        s1_sum_s = '0;
        if (i_sub) begin
            s1_sum_s = {1'b0, i_dat_a} - {1'b0, i_dat_b};
        end else begin
            s1_sum_s = {1'b0, i_dat_a} + {1'b0, i_dat_b};
        end
        s1_err_s = i_err | out_of_range(i_dat_a) | out_of_range(i_dat_b);
    end

    // Stage 2 correction: subtract P once after an add, add P back after a borrowing sub.
    always_comb begin
        s2_res_s = s1_sum_r[DAT_BITS-1:0];
        if (s1_sub_r) begin
            if (s1_sum_r[DAT_BITS]) begin
                s2_res_s = s1_sum_r[DAT_BITS-1:0] + P;
            end else begin
                s2_res_s = s1_sum_r[DAT_BITS-1:0];
            end
        end else begin
            if (s1_sum_r >= {1'b0, P}) begin
                s2_res_s = s1_sum_r[DAT_BITS-1:0] - P;
            end else begin
                s2_res_s = s1_sum_r[DAT_BITS-1:0];
            end
        end
    end

    // Stage 1 register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_val_r <= 1'b0;
            s1_sum_r <= '0;
            s1_sub_r <= 1'b0;
            s1_ctl_r <= '0;
            s1_err_r <= 1'b0;
        end else if (s1_adv_s) begin
            s1_val_r <= i_val;
            if (i_val) begin
                s1_sum_r <= s1_sum_s;
                s1_sub_r <= i_sub;
                s1_ctl_r <= i_ctl;
                s1_err_r <= s1_err_s;
            end
        end
    end

    // Output register; holds its beat while downstream stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_val <= 1'b0;
            o_dat <= '0;
            o_ctl <= '0;
            o_err <= 1'b0;
        end else if (s2_adv_s) begin
            o_val <= s1_val_r;
            if (s1_val_r) begin
                o_dat <= s2_res_s;
                o_ctl <= s1_ctl_r;
                o_err <= s1_err_r;
            end
        end
    end

endmodule

// File: tb/tb_secp256k1_addsub_mod.sv
// Self-checking bench for secp256k1_addsub_mod: directed cases plus randomized
// traffic with random backpressure, scored against an arithmetic field model.
module tb_secp256k1_addsub_mod;

    localparam int DAT_BITS = 256;
    localparam int CTL_BITS = 16;
    localparam logic [255:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;

    logic                i_clk;
    logic                i_rst_n;
    logic [DAT_BITS-1:0] i_dat_a;
    logic [DAT_BITS-1:0] i_dat_b;
    logic                i_sub;
    logic [CTL_BITS-1:0] i_ctl;
    logic                i_err;
    logic                i_val;
    logic                o_rdy;
    logic [DAT_BITS-1:0] o_dat;
    logic [CTL_BITS-1:0] o_ctl;
    logic                o_err;
    logic                o_val;
    logic                i_rdy;

    secp256k1_addsub_mod dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_dat_a (i_dat_a),
        .i_dat_b (i_dat_b),
        .i_sub   (i_sub),
        .i_ctl   (i_ctl),
        .i_err   (i_err),
        .i_val   (i_val),
        .o_rdy   (o_rdy),
        .o_dat   (o_dat),
        .o_ctl   (o_ctl),
        .o_err   (o_err),
        .o_val   (o_val),
        .i_rdy   (i_rdy)
    );

    typedef struct {
        logic [255:0] dat;
        logic [15:0]  ctl;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b0;
    bit   rnd_done = 1'b0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        forever begin
            @(posedge i_clk);
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Field-level reference: true modular result for in-range operands, one correction otherwise.
    function automatic logic [255:0] fe_ref(input logic [255:0] a, input logic [255:0] b, input logic sub);
        logic [257:0] s;
        if (!sub) begin
            s = {2'b00, a} + {2'b00, b};
            if (s >= {2'b00, P}) s = s - {2'b00, P};
        end else if (a >= b) begin
            s = {2'b00, a} - {2'b00, b};
        end else begin
            s = {2'b00, a} + {2'b00, P} - {2'b00, b};
        end
        return s[255:0];
    endfunction

    function automatic logic [255:0] rnd_fe();
        logic [255:0] v;
        int m;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        m = $urandom_range(0, 9);
        case (m)
            0: v = P - 256'($urandom_range(0, 3));
            1: v = 256'($urandom_range(0, 7));
            2: v = P + 256'($urandom_range(0, 3));
            default: v = v;
        endcase
        return v;
    endfunction

    task automatic send(input logic [255:0] a, input logic [255:0] b, input logic sub,
                        input logic [15:0] ctl, input logic err);
        exp_t e;
        int   w;
        i_dat_a = a;
        i_dat_b = b;
        i_sub   = sub;
        i_ctl   = ctl;
        i_err   = err;
        i_val   = 1'b1;
        w = 0;
        @(negedge i_clk);
        while (!o_rdy && w < 50) begin
            w++;
            @(negedge i_clk);
        end
        if (!o_rdy) begin
            check("send_timeout", 256'(o_rdy), 256'd1);
        end else begin
            e.dat = fe_ref(a, b, sub);
            e.ctl = ctl;
            e.err = err | (a >= P) | (b >= P);
            e.cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge i_clk);
        #1;
        i_val = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            w++;
            @(posedge i_clk);
        end
        check("drain_empty", 256'(exp_q.size()), 256'd0);
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    // Output monitor: scoreboard compare, latency, and stall stability.
    initial begin
        exp_t         e;
        bit           hold_v;
        logic [255:0] hold_dat;
        logic [15:0]  hold_ctl;
        logic         hold_err;
        hold_v = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    check("hold_val", 256'(o_val), 256'd1);
                    check("hold_dat", o_dat, hold_dat);
                    check("hold_ctl", 256'(o_ctl), 256'(hold_ctl));
                    check("hold_err", 256'(o_err), 256'(hold_err));
                end
                if (o_val && i_rdy) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out", 256'(o_val), 256'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_dat", o_dat, e.dat);
                        check("out_ctl", 256'(o_ctl), 256'(e.ctl));
                        check("out_err", 256'(o_err), 256'(e.err));
                        if (lat_chk) check("latency", 256'(cyc - e.cyc), 256'd2);
                    end
                end
                hold_v   = o_val && !i_rdy;
                hold_dat = o_dat;
                hold_ctl = o_ctl;
                hold_err = o_err;
            end
        end
    end

    initial begin
        i_rst_n = 1'b0;
        i_dat_a = '0;
        i_dat_b = '0;
        i_sub   = 1'b0;
        i_ctl   = '0;
        i_err   = 1'b0;
        i_val   = 1'b0;
        i_rdy   = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_o_val", 256'(o_val), 256'd0);
        check("rst_o_err", 256'(o_err), 256'd0);
        check("rst_o_dat", o_dat, 256'd0);
        check("rst_o_ctl", 256'(o_ctl), 256'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Directed corner cases with exact latency.
        lat_chk = 1'b1;
        send(P - 256'd1, 256'd1, 1'b0, 16'h00A5, 1'b0);
        send(256'd0, 256'd1, 1'b1, 16'h0001, 1'b0);
        send(256'd5, 256'd3, 1'b1, 16'h0002, 1'b0);
        send(P - 256'd1, P - 256'd1, 1'b0, 16'h0003, 1'b0);
        send(P, 256'd0, 1'b0, 16'h0004, 1'b0);
        send(256'd7, 256'd9, 1'b0, 16'h0005, 1'b1);
        drain();

        // Back-to-back mixed beats, tags 0..7.
        for (int i = 0; i < 8; i++) begin
            send(rnd_fe(), rnd_fe(), i[0], 16'(i), 1'b0);
        end
        drain();

        // Backpressure: two beats fill the pipe, then o_rdy must drop.
        lat_chk = 1'b0;
        i_rdy = 1'b0;
        send(rnd_fe(), rnd_fe(), 1'b0, 16'h0010, 1'b0);
        send(rnd_fe(), rnd_fe(), 1'b1, 16'h0011, 1'b0);
        i_val = 1'b1;
        @(negedge i_clk);
        check("o_rdy_full", 256'(o_rdy), 256'd0);
        fork
            begin
                repeat (3) @(posedge i_clk);
                #1;
                i_rdy = 1'b1;
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    send(rnd_fe(), rnd_fe(), i[1], 16'(16'h0012 + i), 1'b0);
                end
            end
        join
        drain();

        // Async reset with both stages full drops everything.
        i_rdy = 1'b0;
        send(rnd_fe(), rnd_fe(), 1'b0, 16'h0020, 1'b0);
        send(rnd_fe(), rnd_fe(), 1'b0, 16'h0021, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("async_rst_val", 256'(o_val), 256'd0);
        exp_q.delete();
        repeat (2) @(posedge i_clk);
        #3;
        i_rst_n = 1'b1;
        i_rdy = 1'b1;
        repeat (5) @(posedge i_clk);
        #1;
        lat_chk = 1'b1;
        send(256'd11, 256'd22, 1'b0, 16'h0030, 1'b0);
        drain();

        // Randomized traffic with random downstream stalls.
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(rnd_fe(), rnd_fe(), 1'($urandom_range(0, 1)), 16'($urandom()),
                         ($urandom_range(0, 15) == 0));
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge i_clk);
                        #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge i_clk);
                    #1;
                    i_rdy = ($urandom_range(0, 3) != 0);
                end
                i_rdy = 1'b1;
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
